input_synch_multi: RTL and testbench



---
 rtl/input_synch_multi_if.sv | 21 ++
 rtl/input_synch_multi.sv | 97 +++++++++
 tb/tb_input_synch_multi.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/input_synch_multi_if.sv
// Bundle of the per-channel input, synchronised, debounced and edge-pulse vectors.
// master drives the raw inputs; slave is the synchroniser producing the rest.
interface input_synch_multi_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] synch_in;
  logic [WIDTH-1:0] synch_out;
  logic [WIDTH-1:0] filt_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (
    output synch_in,
    input  synch_out, filt_out, rise, fall
  );

  modport slave (
    input  synch_in,
    output synch_out, filt_out, rise, fall
  );
endinterface

// File: rtl/input_synch_multi.sv
// Multi-channel pin synchroniser + debounce filter + rise/fall pulses, plus reset synchroniser.
// Latency STAGES edges to synch_out, STAGES+FILTER_LEN to filt_out/pulses; free-running, no backpressure.
module input_synch_multi #(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                sync_reset_n,
  input_synch_multi_if.slave  bus
);

  localparam int              CW      = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(FILTER_LEN - 1);

  generate
    if (WIDTH < 1 || STAGES < 2 || FILTER_LEN < 1) begin : g_param_chk
      $fatal(1, "input_synch_multi: requires WIDTH>=1, STAGES>=2, FILTER_LEN>=1");
    end
  endgenerate

  logic [STAGES-1:0] r_rst_sync;
  logic [WIDTH-1:0]  r_sync [STAGES];
  logic [WIDTH-1:0]  r_filt;
  logic [WIDTH-1:0]  r_rise;
  logic [WIDTH-1:0]  r_fall;
  logic [CW-1:0]     r_cnt  [WIDTH];
  logic [WIDTH-1:0]  w_sync_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[STAGES-2:0], 1'b1};
    end
  end

  assign sync_reset_n = r_rst_sync[STAGES-1];

  // Input chains run on reset_n alone so they are already settled when filtering starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_sync[s] <= RESET_VAL;
      end
    end else begin
      r_sync[0] <= bus.synch_in;
      for (int s = 1; s < STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync_out = r_sync[STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= RESET_VAL;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (!sync_reset_n) begin
      r_filt <= RESET_VAL;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync_out[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          // Pulses are registered alongside filt_out so they align with its first new-value cycle.
          r_filt[i] <= w_sync_out[i];
          r_rise[i] <= w_sync_out[i];
          r_fall[i] <= ~w_sync_out[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign bus.synch_out = w_sync_out;
  assign bus.filt_out  = r_filt;
  assign bus.rise      = r_rise;
  assign bus.fall      = r_fall;

endmodule

// File: tb/tb_input_synch_multi.sv
// Directed bench for input_synch_multi: default build (A) and STAGES=3/FILTER_LEN=1/RESET_VAL=1111 build (B).
// Expected edge pulses are queued with their due cycle and matched by per-instance monitors.
module tb_input_synch_multi;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
  } ev_t;

  logic clk;
  logic rst_a, rst_b;
  logic srst_a, srst_b;
  int   cyc;
  int   n_pass;
  int   n_total;
  int   n_fail;
  ev_t  qa[$];
  ev_t  qb[$];

  input_synch_multi_if #(.WIDTH(4)) ifa ();
  input_synch_multi_if #(.WIDTH(4)) ifb ();

  input_synch_multi #(
    .WIDTH(4), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(4'b0000)
  ) dut_a (
    .clk(clk), .reset_n(rst_a), .sync_reset_n(srst_a), .bus(ifa)
  );

  input_synch_multi #(
    .WIDTH(4), .STAGES(3), .FILTER_LEN(1), .RESET_VAL(4'b1111)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .sync_reset_n(srst_b), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input int c, input logic [3:0] r, input logic [3:0] f);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f;
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [3:0] r, input logic [3:0] f);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f;
    qb.push_back(e);
  endtask

  task automatic wait_filt_a(input logic [3:0] exp, input string tag);
    int n;
    n = 0;
    while (ifa.filt_out !== exp && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, {28'd0, ifa.filt_out}, {28'd0, exp});
  endtask

  task automatic wait_filt_b(input logic [3:0] exp, input string tag);
    int n;
    n = 0;
    while (ifb.filt_out !== exp && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, {28'd0, ifb.filt_out}, {28'd0, exp});
  endtask

  // Pulse monitors: every nonzero rise/fall must match the oldest queued event, on its due cycle.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (ifa.rise !== 4'b0 || ifa.fall !== 4'b0) begin
        if (qa.size() == 0) begin
          check("a_unexpected_pulse", {24'd0, ifa.rise, ifa.fall}, 32'd0);
        end else begin
          e = qa.pop_front();
          check("a_pulse_cycle", cyc, e.cyc);
          check("a_rise", {28'd0, ifa.rise}, {28'd0, e.rise});
          check("a_fall", {28'd0, ifa.fall}, {28'd0, e.fall});
        end
      end
    end
  end

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (ifb.rise !== 4'b0 || ifb.fall !== 4'b0) begin
        if (qb.size() == 0) begin
          check("b_unexpected_pulse", {24'd0, ifb.rise, ifb.fall}, 32'd0);
        end else begin
          e = qb.pop_front();
          check("b_pulse_cycle", cyc, e.cyc);
          check("b_rise", {28'd0, ifb.rise}, {28'd0, e.rise});
          check("b_fall", {28'd0, ifb.fall}, {28'd0, e.fall});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int hc;
    int k0;
    n_pass  = 0;
    n_total = 0;
    n_fail  = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.synch_in = 4'b0000;
    ifb.synch_in = 4'b1111;

    // Reset asserted between clock edges: outputs must clear without any edge.
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("a_rst_sync_reset_n", {31'd0, srst_a}, 32'd0);
    check("a_rst_synch_out", {28'd0, ifa.synch_out}, 32'd0);
    check("a_rst_filt_out", {28'd0, ifa.filt_out}, 32'd0);
    check("a_rst_rise_fall", {24'd0, ifa.rise, ifa.fall}, 32'd0);
    check("b_rst_sync_reset_n", {31'd0, srst_b}, 32'd0);
    check("b_rst_synch_out", {28'd0, ifb.synch_out}, 32'hF);
    check("b_rst_filt_out", {28'd0, ifb.filt_out}, 32'hF);

    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    check("a_srst_after_1_edge", {31'd0, srst_a}, 32'd0);
    @(negedge clk);
    check("a_srst_after_2_edges", {31'd0, srst_a}, 32'd1);
    check("b_srst_after_2_edges", {31'd0, srst_b}, 32'd0);
    @(negedge clk);
    check("b_srst_after_3_edges", {31'd0, srst_b}, 32'd1);

    // Stable change on channel 0.
    ifa.synch_in = 4'b0001;
    push_a(cyc + 6, 4'b0001, 4'b0000);
    @(negedge clk);
    check("t2_synch_out_1_edge", {28'd0, ifa.synch_out}, 32'd0);
    @(negedge clk);
    check("t2_synch_out_2_edges", {28'd0, ifa.synch_out}, 32'd1);
    check("t2_filt_not_yet", {28'd0, ifa.filt_out}, 32'd0);
    wait_filt_a(4'b0001, "t2_filt_out");

    // Glitch bursts on channel 1: 3 high / 1 low, repeated.
    hc = 0;
    for (int b = 0; b < 3; b++) begin
      ifa.synch_in = 4'b0011;
      repeat (3) begin
        @(negedge clk);
        if (ifa.synch_out[1]) hc++;
      end
      ifa.synch_in = 4'b0001;
      @(negedge clk);
      if (ifa.synch_out[1]) hc++;
    end
    repeat (6) begin
      @(negedge clk);
      if (ifa.synch_out[1]) hc++;
    end
    check("t3_synch_out_high_cycles", hc, 9);
    check("t3_filt_held", {28'd0, ifa.filt_out}, 32'h1);

    // Simultaneous multi-channel changes.
    ifa.synch_in = 4'b0000;
    push_a(cyc + 6, 4'b0000, 4'b0001);
    wait_filt_a(4'b0000, "t4_filt_clear");
    ifa.synch_in = 4'b1010;
    push_a(cyc + 6, 4'b1010, 4'b0000);
    wait_filt_a(4'b1010, "t4_filt_1010");
    ifa.synch_in = 4'b0101;
    push_a(cyc + 6, 4'b0101, 4'b1010);
    wait_filt_a(4'b0101, "t4_filt_0101");

    // Reset mid-count: channel 2 falling, counter at 2 when reset drops.
    ifa.synch_in = 4'b0001;
    repeat (4) @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("t5_async_filt", {28'd0, ifa.filt_out}, 32'd0);
    check("t5_async_srst", {31'd0, srst_a}, 32'd0);
    check("t5_async_synch_out", {28'd0, ifa.synch_out}, 32'd0);
    check("t5_async_rise_fall", {24'd0, ifa.rise, ifa.fall}, 32'd0);
    ifa.synch_in = 4'b0101;
    @(negedge clk);
    rst_a = 1'b1;
    k0 = cyc;
    push_a(k0 + 6, 4'b0101, 4'b0000);
    repeat (5) @(negedge clk);
    check("t5_filt_hold_before_full_run", {28'd0, ifa.filt_out}, 32'd0);
    wait_filt_a(4'b0101, "t5_filt_after_run");

    // Second build: idle high, single-sample filter.
    check("t6_idle_filt", {28'd0, ifb.filt_out}, 32'hF);
    check("t6_idle_synch_out", {28'd0, ifb.synch_out}, 32'hF);
    ifb.synch_in = 4'b0111;
    push_b(cyc + 4, 4'b0000, 4'b1000);
    repeat (3) @(negedge clk);
    check("t6_filt_before_4_edges", {28'd0, ifb.filt_out}, 32'hF);
    wait_filt_b(4'b0111, "t6_filt_out");

    repeat (6) @(negedge clk);
    check("a_pending_events", qa.size(), 0);
    check("b_pending_events", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
